// File: rtl/timer0_irq_pkg.sv
// Timer0 interrupt responder: shared types and constants.
// Contents: FSM state enum, TIFR/TIMSK bit indices, source encodings,
// default vector addresses and a source-to-flag-mask helper.
package timer0_irq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        CLEAR   = 3'd2,
        SERVICE = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    localparam int TOV0 = 0;
    localparam int OCF0 = 1;

    // Encodings line up with the TIFR bit positions so a source doubles as its flag mask.
    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_OVF  = 2'b01;
    localparam logic [1:0] SRC_COMP = 2'b10;

    localparam logic [15:0] DEF_VEC_COMP = 16'h0014;
    localparam logic [15:0] DEF_VEC_OVF  = 16'h0016;

    function automatic logic [7:0] src_mask(input logic [1:0] src);
        return {6'b000000, src};
    endfunction

endpackage

// File: rtl/timer0_interrupt_responder_if.sv
// Bus between the CPU core / Timer0 side (master) and the interrupt responder (slave).
// Inputs to responder: TIFR_in, TIMSK_in, global_int_enable, instr_boundary, irq_ack, reti_done.
// Outputs from responder: irq_request, irq_vector, irq_source, TIFR_clear_data,
// TIFR_clear_write_enable, clear_global_int, busy.
// With TIMER0_IRQ_STATS_EN defined: stats_clear (in), comp_count/ovf_count (out).
interface timer0_interrupt_responder_if;
    logic [7:0]  TIFR_in;
    logic [7:0]  TIMSK_in;
    logic        global_int_enable;
    logic        instr_boundary;
    logic        irq_ack;
    logic        reti_done;
    logic        irq_request;
    logic [15:0] irq_vector;
    logic [1:0]  irq_source;
    logic [7:0]  TIFR_clear_data;
    logic        TIFR_clear_write_enable;
    logic        clear_global_int;
    logic        busy;
`ifdef TIMER0_IRQ_STATS_EN
    logic        stats_clear;
    logic [7:0]  comp_count;
    logic [7:0]  ovf_count;
`endif

    modport master (
        output TIFR_in, TIMSK_in, global_int_enable, instr_boundary, irq_ack, reti_done,
        input  irq_request, irq_vector, irq_source, TIFR_clear_data,
               TIFR_clear_write_enable, clear_global_int, busy
`ifdef TIMER0_IRQ_STATS_EN
        , output stats_clear
        , input  comp_count, ovf_count
`endif
    );

    modport slave (
        input  TIFR_in, TIMSK_in, global_int_enable, instr_boundary, irq_ack, reti_done,
        output irq_request, irq_vector, irq_source, TIFR_clear_data,
               TIFR_clear_write_enable, clear_global_int, busy
`ifdef TIMER0_IRQ_STATS_EN
        , input  stats_clear
        , output comp_count, ovf_count
`endif
    );

endinterface

// File: rtl/timer0_irq_arbiter.sv
// Combinational priority select between TIMER0_COMP and TIMER0_OVF.
// Ports: flags/mask - TIFR/TIMSK bits [1:0]; src - winning source (SRC_NONE if none);
// vec - vector word address of the winner (0 if none). COMP beats OVF.
module timer0_irq_arbiter
    import timer0_irq_pkg::*;
#(
    parameter logic [15:0] VEC_COMP = DEF_VEC_COMP,
    parameter logic [15:0] VEC_OVF  = DEF_VEC_OVF
) (
    input  logic [1:0]  flags,
    input  logic [1:0]  mask,
    output logic [1:0]  src,
    output logic [15:0] vec
);

    always_comb begin
        src = SRC_NONE;
        vec = 16'h0000;
        if (flags[OCF0] & mask[OCF0]) begin
            src = SRC_COMP;
            vec = VEC_COMP;
        end else if (flags[TOV0] & mask[TOV0]) begin
            src = SRC_OVF;
            vec = VEC_OVF;
        end
    end

endmodule

// File: rtl/timer0_interrupt_responder.sv
// Timer0 interrupt responder: watches TIFR/TIMSK and the I bit, raises a vectored
// request, clears the serviced flag through the timer's TIFR write port on ack,
// tracks the handler until RETI and enforces an instruction holdoff afterwards.
// Ports: sysClock, system_reset (async, active-high), bus (slave modport of
// timer0_interrupt_responder_if).
// Optional feature: define TIMER0_IRQ_STATS_EN for saturating per-source service counters.
//
// state   | meaning
// IDLE    | waiting for an eligible flag at an instruction boundary with I=1
// REQ     | request raised, source/vector frozen until ack or withdrawal
// CLEAR   | one-cycle TIFR write of the serviced flag, I bit cleared
// SERVICE | handler running, waiting for RETI
// HOLDOFF | counting instruction boundaries after RETI before re-arming
module timer0_interrupt_responder
    import timer0_irq_pkg::*;
#(
    parameter logic [15:0] VEC_COMP      = DEF_VEC_COMP,
    parameter logic [15:0] VEC_OVF       = DEF_VEC_OVF,
    parameter int unsigned HOLDOFF_INSTR = 1
) (
    input  logic sysClock,
    input  logic system_reset,
    timer0_interrupt_responder_if.slave bus
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_INSTR);

    state_t      state;
    logic [1:0]  src_q;
    logic [15:0] vec_q;
    logic        req_q;
    logic        we_q;
    logic        cgi_q;
    logic        busy_q;
    logic [7:0]  hold_cnt;

    logic [1:0]  arb_src;
    logic [15:0] arb_vec;
    logic        latched_ok;
    logic        unused_mask_bits;

    timer0_irq_arbiter #(
        .VEC_COMP (VEC_COMP),
        .VEC_OVF  (VEC_OVF)
    ) u_arbiter (
        .flags (bus.TIFR_in[1:0]),
        .mask  (bus.TIMSK_in[1:0]),
        .src   (arb_src),
        .vec   (arb_vec)
    );

    // Still eligible: the latched source's flag and enable are both present.
    assign latched_ok = |(bus.TIFR_in[1:0] & bus.TIMSK_in[1:0] & src_q);
    assign unused_mask_bits = ^bus.TIMSK_in[7:2];

    always_ff @(posedge sysClock or posedge system_reset) begin
        if (system_reset) begin
            state    <= IDLE;
            src_q    <= SRC_NONE;
            vec_q    <= 16'h0000;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            cgi_q    <= 1'b0;
            busy_q   <= 1'b0;
            hold_cnt <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if ((arb_src != SRC_NONE) && bus.global_int_enable && bus.instr_boundary) begin
                        state <= REQ;
                        req_q <= 1'b1;
                        src_q <= arb_src;
                        vec_q <= arb_vec;
                    end
                end
                REQ: begin
                    if (bus.irq_ack) begin
                        state  <= CLEAR;
                        req_q  <= 1'b0;
                        vec_q  <= 16'h0000;
                        we_q   <= 1'b1;
                        cgi_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end else if (!latched_ok || !bus.global_int_enable) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                        vec_q <= 16'h0000;
                        src_q <= SRC_NONE;
                    end
                end
                CLEAR: begin
                    state <= SERVICE;
                    we_q  <= 1'b0;
                    cgi_q <= 1'b0;
                end
                SERVICE: begin
                    if (bus.reti_done) begin
                        busy_q <= 1'b0;
                        if (HOLD_LOAD == 8'h00) begin
                            state <= IDLE;
                            src_q <= SRC_NONE;
                        end else begin
                            state    <= HOLDOFF;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt == 8'h00) begin
                        state <= IDLE;
                        src_q <= SRC_NONE;
                    end else if (bus.instr_boundary) begin
                        hold_cnt <= hold_cnt - 8'h01;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.irq_request             = req_q;
    assign bus.irq_vector              = vec_q;
    assign bus.irq_source              = src_q;
    assign bus.TIFR_clear_write_enable = we_q;
    assign bus.clear_global_int        = cgi_q;
    assign bus.busy                    = busy_q;
    // Data reflects TIFR in the write cycle itself so untouched flags are written back as seen.
    assign bus.TIFR_clear_data         = we_q ? (bus.TIFR_in & ~src_mask(src_q)) : 8'h00;

`ifdef TIMER0_IRQ_STATS_EN
    logic       enter_clear;
    logic [7:0] comp_cnt;
    logic [7:0] ovf_cnt;

    assign enter_clear = (state == REQ) && bus.irq_ack;

    always_ff @(posedge sysClock or posedge system_reset) begin
        if (system_reset) begin
            comp_cnt <= 8'h00;
            ovf_cnt  <= 8'h00;
        end else if (bus.stats_clear) begin
            comp_cnt <= 8'h00;
            ovf_cnt  <= 8'h00;
        end else if (enter_clear) begin
            if ((src_q == SRC_COMP) && (comp_cnt != 8'hFF)) comp_cnt <= comp_cnt + 8'h01;
            if ((src_q == SRC_OVF)  && (ovf_cnt  != 8'hFF)) ovf_cnt  <= ovf_cnt  + 8'h01;
        end
    end

    assign bus.comp_count = comp_cnt;
    assign bus.ovf_count  = ovf_cnt;
`endif

endmodule

// File: tb/tb_timer0_interrupt_responder.sv
// Self-checking bench for timer0_interrupt_responder: table of input patterns plus
// hand-written multi-cycle sequences; a negedge monitor pops expected requests and
// TIFR writes from scoreboard queues.
module tb_timer0_interrupt_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    timer0_interrupt_responder_if bus();

    timer0_interrupt_responder dut (
        .sysClock     (clk),
        .system_reset (rst),
        .bus          (bus)
    );

    typedef struct {
        logic [7:0]  tifr;
        logic [7:0]  timsk;
        logic        gie;
        logic        exp_req;
        logic [15:0] exp_vec;
        logic [1:0]  exp_src;
        logic [7:0]  exp_clr;
    } vec_t;

    typedef struct {
        logic [15:0] vec;
        logic [1:0]  src;
    } req_t;

    vec_t       tbl [11];
    req_t       req_q [$];
    logic [7:0] clr_q [$];
    req_t       mon_req;
    logic [7:0] mon_clr;
    logic       prev_req = 1'b0;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic boundary();
        bus.instr_boundary = 1'b1;
        tick();
        bus.instr_boundary = 1'b0;
    endtask

    task automatic expect_irq(input logic [15:0] v, input logic [1:0] s, input logic [7:0] c);
        req_t r;
        r.vec = v;
        r.src = s;
        req_q.push_back(r);
        clr_q.push_back(c);
    endtask

    // Ack through RETI; tifr_after models the timer applying the clear write.
    task automatic do_service(input logic [7:0] tifr_after);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk("clear_irq_request_low", {31'b0, bus.irq_request}, 32'd0);
        chk("clear_busy", {31'b0, bus.busy}, 32'd1);
        tick();
        chk("service_write_done", {31'b0, bus.TIFR_clear_write_enable}, 32'd0);
        chk("service_cgi_done", {31'b0, bus.clear_global_int}, 32'd0);
        bus.TIFR_in = tifr_after;
        bus.reti_done = 1'b1;
        tick();
        bus.reti_done = 1'b0;
        chk("reti_busy_low", {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic finish_holdoff();
        boundary();
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.irq_request && !prev_req) begin
                chk("request_expected", {31'b0, req_q.size() != 0}, 32'd1);
                if (req_q.size() != 0) begin
                    mon_req = req_q.pop_front();
                    chk("req_vector", {16'b0, bus.irq_vector}, {16'b0, mon_req.vec});
                    chk("req_source", {30'b0, bus.irq_source}, {30'b0, mon_req.src});
                end
            end
            if (bus.TIFR_clear_write_enable) begin
                chk("write_expected", {31'b0, clr_q.size() != 0}, 32'd1);
                if (clr_q.size() != 0) begin
                    mon_clr = clr_q.pop_front();
                    chk("clear_data", {24'b0, bus.TIFR_clear_data}, {24'b0, mon_clr});
                    chk("clear_gie_pulse", {31'b0, bus.clear_global_int}, 32'd1);
                end
            end
        end
        prev_req <= bus.irq_request;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'h01, 8'h01, 1'b1, 1'b1, 16'h0016, 2'b01, 8'h00};
        tbl[1]  = '{8'h03, 8'h03, 1'b1, 1'b1, 16'h0014, 2'b10, 8'h01};
        tbl[2]  = '{8'h02, 8'h02, 1'b1, 1'b1, 16'h0014, 2'b10, 8'h00};
        tbl[3]  = '{8'h03, 8'h01, 1'b1, 1'b1, 16'h0016, 2'b01, 8'h02};
        tbl[4]  = '{8'h03, 8'h02, 1'b1, 1'b1, 16'h0014, 2'b10, 8'h01};
        tbl[5]  = '{8'h01, 8'h02, 1'b1, 1'b0, 16'h0000, 2'b00, 8'h00};
        tbl[6]  = '{8'h02, 8'h01, 1'b1, 1'b0, 16'h0000, 2'b00, 8'h00};
        tbl[7]  = '{8'h03, 8'h03, 1'b0, 1'b0, 16'h0000, 2'b00, 8'h00};
        tbl[8]  = '{8'hFF, 8'hFF, 1'b1, 1'b1, 16'h0014, 2'b10, 8'hFD};
        tbl[9]  = '{8'hFE, 8'hFD, 1'b1, 1'b0, 16'h0000, 2'b00, 8'h00};
        tbl[10] = '{8'h81, 8'h81, 1'b1, 1'b1, 16'h0016, 2'b01, 8'h80};

        bus.TIFR_in = 8'h00;
        bus.TIMSK_in = 8'h00;
        bus.global_int_enable = 1'b0;
        bus.instr_boundary = 1'b0;
        bus.irq_ack = 1'b0;
        bus.reti_done = 1'b0;
`ifdef TIMER0_IRQ_STATS_EN
        bus.stats_clear = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        chk("rst_irq_request", {31'b0, bus.irq_request}, 32'd0);
        chk("rst_irq_vector", {16'b0, bus.irq_vector}, 32'd0);
        chk("rst_irq_source", {30'b0, bus.irq_source}, 32'd0);
        chk("rst_clear_we", {31'b0, bus.TIFR_clear_write_enable}, 32'd0);
        chk("rst_clear_data", {24'b0, bus.TIFR_clear_data}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven patterns
        for (int i = 0; i < 11; i++) begin
            bus.TIFR_in = tbl[i].tifr;
            bus.TIMSK_in = tbl[i].timsk;
            bus.global_int_enable = tbl[i].gie;
            if (tbl[i].exp_req) expect_irq(tbl[i].exp_vec, tbl[i].exp_src, tbl[i].exp_clr);
            boundary();
            chk("table_request", {31'b0, bus.irq_request}, {31'b0, tbl[i].exp_req});
            if (tbl[i].exp_req) begin
                do_service(tbl[i].exp_clr);
                finish_holdoff();
            end else begin
                tick();
            end
            bus.TIFR_in = 8'h00;
            bus.TIMSK_in = 8'h00;
            bus.global_int_enable = 1'b0;
            tick();
        end

        // COMP first, OVF after RETI and the holdoff boundary
        bus.TIFR_in = 8'h03;
        bus.TIMSK_in = 8'h03;
        bus.global_int_enable = 1'b1;
        expect_irq(16'h0014, 2'b10, 8'h01);
        boundary();
        do_service(8'h01);
        boundary();
        chk("holdoff_blocks_request", {31'b0, bus.irq_request}, 32'd0);
        chk("holdoff_source_held", {30'b0, bus.irq_source}, 32'd2);
        tick();
        chk("holdoff_exit_source", {30'b0, bus.irq_source}, 32'd0);
        expect_irq(16'h0016, 2'b01, 8'h00);
        boundary();
        chk("second_request", {31'b0, bus.irq_request}, 32'd1);
        do_service(8'h00);
        finish_holdoff();

        // Withdrawal by mask drop, then ack racing a mask drop
        bus.TIFR_in = 8'h01;
        bus.TIMSK_in = 8'h01;
        begin
            req_t r;
            r.vec = 16'h0016;
            r.src = 2'b01;
            req_q.push_back(r);
        end
        boundary();
        chk("withdraw_pre_req", {31'b0, bus.irq_request}, 32'd1);
        bus.TIMSK_in = 8'h00;
        tick();
        chk("withdraw_req", {31'b0, bus.irq_request}, 32'd0);
        chk("withdraw_vector", {16'b0, bus.irq_vector}, 32'd0);
        chk("withdraw_source", {30'b0, bus.irq_source}, 32'd0);
        tick();
        tick();
        bus.TIMSK_in = 8'h01;
        expect_irq(16'h0016, 2'b01, 8'h00);
        boundary();
        bus.TIMSK_in = 8'h00;
        do_service(8'h00);
        finish_holdoff();

        // Withdrawal by I bit drop
        bus.TIFR_in = 8'h02;
        bus.TIMSK_in = 8'h02;
        begin
            req_t r;
            r.vec = 16'h0014;
            r.src = 2'b10;
            req_q.push_back(r);
        end
        boundary();
        bus.global_int_enable = 1'b0;
        tick();
        chk("withdraw_gie_req", {31'b0, bus.irq_request}, 32'd0);

        // I=0 for ten boundaries, then raise I
        for (int k = 0; k < 10; k++) begin
            boundary();
            chk("gie_low_no_req", {31'b0, bus.irq_request}, 32'd0);
        end
        bus.global_int_enable = 1'b1;
        expect_irq(16'h0014, 2'b10, 8'h00);
        boundary();
        chk("gie_high_req", {31'b0, bus.irq_request}, 32'd1);
        do_service(8'h00);
        finish_holdoff();

        // Reset during SERVICE
        bus.TIFR_in = 8'h01;
        bus.TIMSK_in = 8'h01;
        expect_irq(16'h0016, 2'b01, 8'h00);
        boundary();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        tick();
        chk("service_busy", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("async_rst_req", {31'b0, bus.irq_request}, 32'd0);
        chk("async_rst_source", {30'b0, bus.irq_source}, 32'd0);
        chk("async_rst_we", {31'b0, bus.TIFR_clear_write_enable}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        expect_irq(16'h0016, 2'b01, 8'h00);
        boundary();
        chk("post_rst_req", {31'b0, bus.irq_request}, 32'd1);
        do_service(8'h00);
        finish_holdoff();

`ifdef TIMER0_IRQ_STATS_EN
        bus.stats_clear = 1'b1;
        tick();
        bus.stats_clear = 1'b0;
        chk("stats_cleared_ovf", {24'b0, bus.ovf_count}, 32'd0);
        for (int n = 1; n <= 300; n++) begin
            bus.TIFR_in = 8'h01;
            bus.TIMSK_in = 8'h01;
            expect_irq(16'h0016, 2'b01, 8'h00);
            boundary();
            do_service(8'h00);
            finish_holdoff();
            if (n == 100) chk("ovf_count_100", {24'b0, bus.ovf_count}, 32'd100);
        end
        chk("ovf_count_sat", {24'b0, bus.ovf_count}, 32'hFF);
        chk("comp_count_zero", {24'b0, bus.comp_count}, 32'd0);
        bus.stats_clear = 1'b1;
        tick();
        bus.stats_clear = 1'b0;
        chk("stats_clear_ovf", {24'b0, bus.ovf_count}, 32'd0);
`endif

        tick();
        tick();
        chk("req_queue_drained", req_q.size(), 32'd0);
        chk("clr_queue_drained", clr_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer0_interrupt_responder.md
Name: timer0_interrupt_responder

Overview:
CPU-side consumer of the Timer0 interrupt flags produced by the 8-bit Timer0 block. Monitors TIFR/TIMSK and the global interrupt enable, and arbitrates TIMER0_COMP over TIMER0_OVF. Issues a vectored request to the CPU core and, on acknowledge, clears the serviced flag through the timer's TIFR write port. Tracks the service window until RETI, then enforces the one-instruction holdoff before the next interrupt.

Parameters:
VEC_COMP, 16'h0014, word address of the TIMER0_COMP vector
VEC_OVF, 16'h0016, word address of the TIMER0_OVF vector
HOLDOFF_INSTR, 1, instruction boundaries after RETI before a new request may be raised (0 = none)

Ports:
sysClock  in  1  system clock; all state updates on its rising edge
system_reset  in  1  asynchronous, active-high reset
TIFR_in  in  8  live TIFR from Timer0 (bit1 OCF0, bit0 TOV0)
TIMSK_in  in  8  live TIMSK (bit1 OCIE0, bit0 TOIE0)
global_int_enable  in  1  SREG I bit
instr_boundary  in  1  one-cycle pulse: CPU is between instructions
irq_ack  in  1  CPU accepts the current request (vector fetched)
reti_done  in  1  one-cycle pulse: RETI executed
irq_request  out  1  interrupt request to CPU
irq_vector  out  16  vector word address; valid while irq_request=1
irq_source  out  2  2'b10 COMP, 2'b01 OVF, 2'b00 none
TIFR_clear_data  out  8  data to the timer's TIFR_input
TIFR_clear_write_enable  out  1  strobe to the timer's TIFR_write_enable
clear_global_int  out  1  one-cycle pulse: CPU clears the I bit
busy  out  1  high from ack until RETI

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; irq_vector 16'h0000; holdoff counter 0.
- Eligibility (combinational): comp_ok = TIFR_in[1]&TIMSK_in[1]; ovf_ok = TIFR_in[0]&TIMSK_in[0]. COMP has priority when both are set.
- IDLE: if (comp_ok|ovf_ok) & global_int_enable & instr_boundary, latch source and vector, then go to REQ. Outputs are registered, so irq_request rises 1 cycle after the qualifying boundary.
- REQ: irq_request=1. irq_vector and irq_source are held stable even if a higher-priority flag appears; there is no pre-emption. On irq_ack go to CLEAR.
- REQ withdrawal: if irq_ack=0 and (latched flag or its mask bit drops, or global_int_enable drops), go to IDLE. irq_request, irq_source and irq_vector return to 0 next cycle. If ack and a withdrawal condition occur in the same cycle, ack wins.
- CLEAR (exactly 1 cycle): TIFR_clear_write_enable=1; TIFR_clear_data = TIFR_in with the serviced bit forced to 0, sampled the same cycle. clear_global_int=1. irq_request=0. Then go to SERVICE.
- The write overrides any timer flag update in that same cycle; a flag set by the timer in that exact cycle is lost. This is an accepted limitation.
- SERVICE: busy=1; irq_source held. On reti_done go to HOLDOFF, or go directly to IDLE when HOLDOFF_INSTR=0. New flags stay pending in TIFR.
- HOLDOFF: counter loads HOLDOFF_INSTR and decrements on each instr_boundary. At 0, go to IDLE. irq_source cleared on exit.
- irq_ack outside REQ and reti_done outside SERVICE are ignored.
- Reset asserted mid-state returns to IDLE immediately with no TIFR write.

Optional Feature:
Macro TIMER0_IRQ_STATS_EN.
- Defined: adds outputs comp_count[7:0] and ovf_count[7:0]. Each increments on entry to CLEAR for its source, saturates at 8'hFF, resets to 0, and clears when input stats_clear=1. stats_clear has priority over increment.
- Undefined: no counters and no stats ports; behaviour is otherwise identical.

Decomposition:
- Package timer0_irq_pkg: state enum (IDLE, REQ, CLEAR, SERVICE, HOLDOFF); bit indices TOV0=0, OCF0=1; source encodings SRC_NONE/SRC_OVF/SRC_COMP; default vector constants.
- Sub-module timer0_irq_arbiter: combinational priority select producing source and vector from TIFR/TIMSK. The FSM stays in the top module.

Test Plan:
- TIFR=8'h01, TIMSK=8'h01, I=1, boundary pulse -> irq_request next cycle, vector 16'h0016, source 2'b01. Ack -> one-cycle TIFR write of 8'h00 plus clear_global_int pulse.
- TIFR=8'h03, TIMSK=8'h03 -> vector 16'h0014 (COMP). Clear write data 8'h01. After reti_done plus 1 boundary, second request with vector 16'h0016.
- In REQ, drop TIMSK to 8'h00 with no ack -> irq_request 0 next cycle, no TIFR write. Repeat with ack in the same cycle -> CLEAR still occurs.
- I=0 with TIFR=8'h02, TIMSK=8'h02 for 10 boundaries -> no request. Raise I -> request on the next boundary.
- Assert system_reset during SERVICE -> all outputs 0 asynchronously, busy 0. After release, a pending flag re-requests normally.
- With TIMER0_IRQ_STATS_EN: 300 OVF services -> ovf_count saturates at 8'hFF. stats_clear -> 8'h00.
